rgbtoyuv444: RTL
================

# rgbtoyuv444

Streaming colour-space converter: accepts packed RGB888 pixels (two per 64-bit beat) on a nasti stream slave port and emits packed Y'UV444 (BT.601 studio range, integer approximation) on a nasti stream master port. It is the inverse stage of the video chain's YUV-to-RGB converter and sits in the same crossbar-attached processing chain, using the same `t_user`/`t_dest` routing convention. Fully pipelined: one beat per cycle sustained, no combinational ready path from `dst` to `src`.

## Interface
- `DATA_WIDTH`, 64: stream data width; only 64 is supported (two pixels per beat).
- `USER_WIDTH`, 1: width of `t_user`.
- `DEST_WIDTH`, 1: width of `t_dest`.
- `CHAIN_ID`, 0: `t_dest` value emitted when the beat is forwarded along the chain.

Ports:
- `aclk`  in  1  single clock; all logic on rising edge.
- `areset`  in  1  reset, synchronous, active-high.
- `src`  nasti_stream_channel.slave  DATA_WIDTH  RGB input: per 32-bit pixel, byte0 B, byte1 G, byte2 R, byte3 ignored; pixel 0 in [31:0], pixel 1 in [63:32].
- `dst`  nasti_stream_channel.master  DATA_WIDTH  YUV output: per pixel, byte0 V, byte1 U, byte2 Y, byte3 8'h00.

## Operation
- Input FIFO: 2 entries. `src.t_ready` = (count != 2) && !areset, derived from registered count only. Push on `src` handshake; pop when stage 1 loads.
- Stage 1 (multiply): per pixel, nine signed 32-bit products: 66R, 129G, 25B, 38R, 74G, 112B, 112R, 94G, 18B. Operands zero-extended 8-bit.
- Stage 2 (sum): sY = 66R+129G+25B+128; sU = −38R−74G+112B+128; sV = 112R−94G−18B+128; each arithmetically shifted right 8 (floor).
- Stage 3 (output): Y = sY+16, U = sU+128, V = sV+128; each clamped to 0..255 (range is provably 16..240; clamp retained for safety). Byte3 = 0.
- Sideband carried in lockstep with data: `t_last` passes unchanged; `dst.t_user` = `t_user >> 1`; `dst.t_dest` = `t_user[0] ? CHAIN_ID : 0`.
- `dst.t_strb` and `dst.t_keep` all ones; `dst.t_id` = 0. Input beat with any `t_keep`/`t_strb` bit 0: simulation assertion error; data processed as if all ones.
- Stage advance: stage k loads when its upstream holds valid data and (stage k empty, or stage k is loading into k+1 this cycle). Output stage empties on `dst.t_valid && dst.t_ready`. A stage's valid flag clears only when it drains without being reloaded.

## Timing
- Reset (areset high at an edge): FIFO count 0, all stage valids 0, `dst.t_valid` 0, `dst.t_last` 0, `dst.t_user`/`dst.t_dest` 0; `src.t_ready` 0 while areset high, 1 in the first cycle after release. Data registers need no reset.
- Reset mid-stream: all in-flight beats discarded; no partial beat emitted afterwards.
- Latency: beat accepted at edge N (FIFO empty, pipeline empty, `dst.t_ready` high) → stage 1 at N+1, stage 2 at N+2, `dst.t_valid` high with that beat after edge N+3.
- Throughput: 1 beat/cycle with `dst.t_ready` held high; `src.t_ready` never drops in that case.
- Backpressure: `dst.t_ready` low holds `dst` payload stable with `t_valid` high. Pipeline compresses; with 3 stages + 2 FIFO entries, up to 5 beats buffered; `src.t_ready` falls the cycle after the FIFO reaches 2. Release resumes with no beat lost, duplicated or reordered.
- Simultaneous push and pop at FIFO count 2 is not possible (ready low); at count 1 leaves count 1.

## Test plan
- Reset then single beat pixel0 = white (R=G=B=255), pixel1 = black → dst [31:0] = 0x00EB8080, [63:32] = 0x00108080, valid exactly 3 edges after acceptance.
- Beat pixel0 = pure red (R=255), pixel1 = pure blue (B=255) → pixel0 Y=82,U=90,V=240 (0x00525AF0); pixel1 Y=41,U=240,V=110 (0x0029F06E).
- 100 random beats, `dst.t_ready` constantly high → one output per cycle, all match golden model, `src.t_ready` never low.
- Same stream with random `dst.t_ready` (50%) → identical output sequence, payload stable while stalled, ≤5 beats in flight, `src.t_ready` low only when FIFO full.
- `t_user` = 1 / 0 with CHAIN_ID=3, `t_last` on final beat → `dst.t_dest` 3 / 0, `dst.t_user` 0, `t_last` on matching output beat only.
- Assert areset with 4 beats in flight, `dst.t_ready` low → `dst.t_valid` 0 after the reset edge, `src.t_ready` 1 the following cycle, no stale beat ever emitted.

Source files
------------

// File: rtl/rgbtoyuv444.sv
// rgbtoyuv444: streaming RGB888 -> Y'UV444 (BT.601 studio range) converter.
// Two pixels per 64-bit beat. A 2-entry input FIFO decouples src ready from the
// downstream handshake; a 3-stage multiply/sum/clamp pipeline compresses under
// backpressure so up to five beats can be buffered.
module rgbtoyuv444 #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int CHAIN_ID   = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    // RGB input stream
    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_strb,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic                    src_t_last,
    input  logic [ID_WIDTH-1:0]     src_t_id,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,
    input  logic [USER_WIDTH-1:0]   src_t_user,
    // YUV output stream
    output logic                    dst_t_valid,
    input  logic                    dst_t_ready,
    output logic [DATA_WIDTH-1:0]   dst_t_data,
    output logic [DATA_WIDTH/8-1:0] dst_t_strb,
    output logic [DATA_WIDTH/8-1:0] dst_t_keep,
    output logic                    dst_t_last,
    output logic [ID_WIDTH-1:0]     dst_t_id,
    output logic [DEST_WIDTH-1:0]   dst_t_dest,
    output logic [USER_WIDTH-1:0]   dst_t_user
);

    localparam int NPIX = DATA_WIDTH / 32;
    localparam int RGBW = NPIX * 24;
    localparam logic [DEST_WIDTH-1:0] CHAIN_DEST = DEST_WIDTH'(CHAIN_ID);

    // Saturate a signed intermediate to an unsigned byte.
    function automatic logic [7:0] clamp8(input logic signed [31:0] x);
        if (x < 32'sd0) begin
            return 8'd0;
        end
        if (x > 32'sd255) begin
            return 8'd255;
        end
        return x[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Input FIFO (2 entries). Only the RGB bytes are stored; alpha bytes
    // are dropped on entry.
    // ------------------------------------------------------------------
    logic [RGBW-1:0]       fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic [USER_WIDTH-1:0] fifo_user_q [2];
    logic [1:0]            fifo_count_q, fifo_count_d;
    logic                  fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic                  fifo_push, fifo_pop;
    logic [RGBW-1:0]       fifo_wdata;
    logic [RGBW-1:0]       fifo_head;
    logic [NPIX*8-1:0]     unused_alpha;
    logic                  unused_inputs;

    // Pipeline control
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;
    logic s1_load, s2_load, s3_load, out_fire;

    // Sideband travelling with the data
    logic                  s1_last_q, s2_last_q;
    logic [USER_WIDTH-1:0] s1_user_q, s2_user_q;
    logic                  dst_last_q;
    logic [USER_WIDTH-1:0] dst_user_q;
    logic [DEST_WIDTH-1:0] dst_dest_q;

    // Ready depends only on the registered occupancy and reset.
    assign src_t_ready = (fifo_count_q != 2'd2) && !areset;
    assign fifo_head   = fifo_data_q[fifo_rd_ptr_q];
    assign unused_inputs = ^{unused_alpha, src_t_id, src_t_dest};

    // Stage handshakes: a stage loads when its upstream is valid and it is
    // either empty or draining into the next stage in the same cycle.
    always_comb begin
        out_fire     = s3_valid_q && dst_t_ready;
        s3_load      = s2_valid_q && (!s3_valid_q || out_fire);
        s2_load      = s1_valid_q && (!s2_valid_q || s3_load);
        s1_load      = (fifo_count_q != 2'd0) && (!s1_valid_q || s2_load);
        fifo_push    = src_t_valid && src_t_ready;
        fifo_pop     = s1_load;

        s1_valid_d   = s1_load ? 1'b1 : (s2_load  ? 1'b0 : s1_valid_q);
        s2_valid_d   = s2_load ? 1'b1 : (s3_load  ? 1'b0 : s2_valid_q);
        s3_valid_d   = s3_load ? 1'b1 : (out_fire ? 1'b0 : s3_valid_q);

        fifo_count_d = fifo_count_q;
        if (fifo_push && !fifo_pop) begin
            fifo_count_d = fifo_count_q + 2'd1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_count_d = fifo_count_q - 2'd1;
        end
    end

    // Control state: occupancy, pointers, stage valids, output sideband.
    always_ff @(posedge aclk) begin
        if (areset) begin
            fifo_count_q  <= 2'd0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s3_valid_q    <= 1'b0;
            dst_last_q    <= 1'b0;
            dst_user_q    <= '0;
            dst_dest_q    <= '0;
        end else begin
            fifo_count_q <= fifo_count_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s3_valid_q   <= s3_valid_d;
            if (fifo_push) begin
                fifo_wr_ptr_q <= !fifo_wr_ptr_q;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_q <= !fifo_rd_ptr_q;
            end
            if (s3_load) begin
                dst_last_q <= s2_last_q;
                dst_user_q <= s2_user_q >> 1;
                dst_dest_q <= s2_user_q[0] ? CHAIN_DEST : '0;
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge aclk) begin
        if (fifo_push) begin
            fifo_data_q[fifo_wr_ptr_q] <= fifo_wdata;
            fifo_last_q[fifo_wr_ptr_q] <= src_t_last;
            fifo_user_q[fifo_wr_ptr_q] <= src_t_user;
        end
    end

    // Sideband for stages 1 and 2 (no reset: qualified by the stage valids).
    always_ff @(posedge aclk) begin
        if (s1_load) begin
            s1_last_q <= fifo_last_q[fifo_rd_ptr_q];
            s1_user_q <= fifo_user_q[fifo_rd_ptr_q];
        end
        if (s2_load) begin
            s2_last_q <= s1_last_q;
            s2_user_q <= s1_user_q;
        end
    end

    // Partial strobes are not supported; data is treated as fully valid.
    always_ff @(posedge aclk) begin
        if (fifo_push) begin
            assert (&src_t_keep && &src_t_strb)
                else $error("rgbtoyuv444: input beat with partial t_keep/t_strb");
        end
    end

    // ------------------------------------------------------------------
    // Per-pixel datapath
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            logic [7:0]         r_px, g_px, b_px;
            logic signed [31:0] r_ext, g_ext, b_ext;
            logic signed [31:0] yr_q, yg_q, yb_q;
            logic signed [31:0] ur_q, ug_q, ub_q;
            logic signed [31:0] vr_q, vg_q, vb_q;
            logic signed [31:0] sy_q, su_q, sv_q;
            logic [7:0]         y_q, u_q, v_q;

            assign fifo_wdata[gi*24 +: 24]  = src_t_data[gi*32 +: 24];
            assign unused_alpha[gi*8 +: 8]  = src_t_data[gi*32+24 +: 8];

            assign b_px  = fifo_head[gi*24      +: 8];
            assign g_px  = fifo_head[gi*24 + 8  +: 8];
            assign r_px  = fifo_head[gi*24 + 16 +: 8];
            assign r_ext = signed'({24'd0, r_px});
            assign g_ext = signed'({24'd0, g_px});
            assign b_ext = signed'({24'd0, b_px});

            // Stage 1: the nine coefficient products.
            always_ff @(posedge aclk) begin
                if (s1_load) begin
                    yr_q <= r_ext * 32'sd66;
                    yg_q <= g_ext * 32'sd129;
                    yb_q <= b_ext * 32'sd25;
                    ur_q <= r_ext * 32'sd38;
                    ug_q <= g_ext * 32'sd74;
                    ub_q <= b_ext * 32'sd112;
                    vr_q <= r_ext * 32'sd112;
                    vg_q <= g_ext * 32'sd94;
                    vb_q <= b_ext * 32'sd18;
                end
            end

            // Stage 2: rounded sums, floor-shifted by 8.
            always_ff @(posedge aclk) begin
                if (s2_load) begin
                    sy_q <= (yr_q + yg_q + yb_q + 32'sd128) >>> 8;
                    su_q <= (ub_q - ur_q - ug_q + 32'sd128) >>> 8;
                    sv_q <= (vr_q - vg_q - vb_q + 32'sd128) >>> 8;
                end
            end

            // Stage 3: add offsets and saturate to bytes.
            always_ff @(posedge aclk) begin
                if (s3_load) begin
                    y_q <= clamp8(sy_q + 32'sd16);
                    u_q <= clamp8(su_q + 32'sd128);
                    v_q <= clamp8(sv_q + 32'sd128);
                end
            end

            assign dst_t_data[gi*32 +: 32] = {8'h00, y_q, u_q, v_q};
        end
    endgenerate

    assign dst_t_valid = s3_valid_q;
    assign dst_t_last  = dst_last_q;
    assign dst_t_user  = dst_user_q;
    assign dst_t_dest  = dst_dest_q;
    assign dst_t_strb  = '1;
    assign dst_t_keep  = '1;
    assign dst_t_id    = '0;

endmodule
